// File: rtl/d5m_capture_ctrl.sv
// D5M pixel front end: registers the sensor bus, tracks frame/line position and emits an armed,
// cropped pixel stream. Optional line-length check is built when D5M_CAP_LINECHK_EN is defined.
module d5m_capture_ctrl #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned X_W    = 12,
  parameter int unsigned Y_W    = 11,
  parameter int unsigned LINE_W = 1280
) (
  input  logic              im_D5M_PIXLCLK,
  input  logic              im_RST,
  input  logic [DATA_W-1:0] im_D5M_D,
  input  logic              im_D5M_FVAL,
  input  logic              im_D5M_LVAL,
  output logic              om_D5M_RESET_N,
  output logic              om_D5M_TRIGGER,
  input  logic              im_START,
  input  logic              im_CONT,
  input  logic [X_W-1:0]    im_X_START,
  input  logic [X_W-1:0]    im_X_END,
  input  logic [Y_W-1:0]    im_Y_START,
  input  logic [Y_W-1:0]    im_Y_END,
  output logic [DATA_W-1:0] om_PIX_DATA,
  output logic              om_PIX_VALID,
  output logic [X_W-1:0]    om_PIX_X,
  output logic [Y_W-1:0]    om_PIX_Y,
  output logic              om_SOF,
  output logic              om_EOL,
  output logic              om_EOF,
  output logic              om_BUSY,
  output logic [15:0]       om_FRAME_CNT,
  output logic              om_LINE_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] d1_q;
  logic              fv1_q, lv1_q, fv_prev_q, lv_prev_q;
  logic              fv_rise, fv_fall, lv_fall;
  logic [X_W-1:0]    x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]    y_cnt_q, y_cnt_d;
  logic [X_W-1:0]    xs_q, xe_q, xs_eff, xe_eff;
  logic [Y_W-1:0]    ys_q, ye_q, ys_eff, ye_eff, y_pix;
  logic              latch_c, eof_c, start_ok_c, in_cap, pix_ok, sof_pend_q;
  logic [DATA_W-1:0] p2_data_q, pix_data_q;
  logic [X_W-1:0]    p2_x_q, pix_x_q;
  logic [Y_W-1:0]    p2_y_q, pix_y_q;
  logic              p2_valid_q, p2_sof_q, p2_eol_q, p2_eof_q;
  logic              pix_valid_q, sof_q, eol_q, eof_q, busy_q;
  logic [15:0]       frame_cnt_q;

  assign om_D5M_RESET_N = ~im_RST;
  assign om_D5M_TRIGGER = 1'b1;

  // Stage 1: pins plus one-cycle-old copies for edge detection
  always_ff @(posedge im_D5M_PIXLCLK or posedge im_RST) begin
    if (im_RST) begin
      d1_q      <= '0;
      fv1_q     <= 1'b0;
      lv1_q     <= 1'b0;
      fv_prev_q <= 1'b0;
      lv_prev_q <= 1'b0;
    end else begin
      d1_q      <= im_D5M_D;
      fv1_q     <= im_D5M_FVAL;
      lv1_q     <= im_D5M_LVAL;
      fv_prev_q <= fv1_q;
      lv_prev_q <= lv1_q;
    end
  end

  assign fv_rise = fv1_q & ~fv_prev_q;
  assign fv_fall = ~fv1_q & fv_prev_q;
  assign lv_fall = ~lv1_q & lv_prev_q;

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (!lv1_q) x_cnt_d = '0;
    else if (fv1_q && (x_cnt_q != '1)) x_cnt_d = x_cnt_q + X_W'(1);
    if (fv_rise) y_cnt_d = '0;
    else if (lv_fall && fv1_q && (y_cnt_q != '1)) y_cnt_d = y_cnt_q + Y_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    latch_c    = 1'b0;
    eof_c      = 1'b0;
    start_ok_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (im_START) begin
          state_d    = ST_ARM;
          start_ok_c = 1'b1;
        end
      end
      ST_ARM: begin
        if (fv_rise) begin
          state_d = ST_CAPTURE;
          latch_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (fv_fall) begin
          eof_c   = 1'b1;
          state_d = im_CONT ? ST_ARM : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The rise cycle itself already uses the freshly latched window and row 0
  assign xs_eff = latch_c ? im_X_START : xs_q;
  assign xe_eff = latch_c ? im_X_END   : xe_q;
  assign ys_eff = latch_c ? im_Y_START : ys_q;
  assign ye_eff = latch_c ? im_Y_END   : ye_q;
  assign y_pix  = fv_rise ? '0 : y_cnt_q;
  assign in_cap = (state_q == ST_CAPTURE) | latch_c;
  assign pix_ok = in_cap & lv1_q & fv1_q & (x_cnt_q >= xs_eff) & (x_cnt_q <= xe_eff)
                & (y_pix >= ys_eff) & (y_pix <= ye_eff);

  always_ff @(posedge im_D5M_PIXLCLK or posedge im_RST) begin
    if (im_RST) begin
      state_q     <= ST_IDLE;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      xs_q        <= '0;
      xe_q        <= '0;
      ys_q        <= '0;
      ye_q        <= '0;
      sof_pend_q  <= 1'b0;
      p2_data_q   <= '0;
      p2_x_q      <= '0;
      p2_y_q      <= '0;
      p2_valid_q  <= 1'b0;
      p2_sof_q    <= 1'b0;
      p2_eol_q    <= 1'b0;
      p2_eof_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      if (latch_c) begin
        xs_q <= im_X_START;
        xe_q <= im_X_END;
        ys_q <= im_Y_START;
        ye_q <= im_Y_END;
      end
      if (pix_ok) sof_pend_q <= 1'b0;
      else if (latch_c) sof_pend_q <= 1'b1;
      // Stage 2 then output stage gives the fixed two-edge latency
      p2_data_q   <= d1_q;
      p2_x_q      <= x_cnt_q;
      p2_y_q      <= y_pix;
      p2_valid_q  <= pix_ok;
      p2_sof_q    <= pix_ok & (sof_pend_q | latch_c);
      p2_eol_q    <= pix_ok & (x_cnt_q == xe_eff);
      p2_eof_q    <= eof_c;
      pix_data_q  <= p2_data_q;
      pix_x_q     <= p2_x_q;
      pix_y_q     <= p2_y_q;
      pix_valid_q <= p2_valid_q;
      sof_q       <= p2_sof_q;
      eol_q       <= p2_eol_q;
      eof_q       <= p2_eof_q;
      busy_q      <= (state_q != ST_IDLE);
      if (p2_eof_q) frame_cnt_q <= frame_cnt_q + 16'(1);
    end
  end

  assign om_PIX_DATA  = pix_data_q;
  assign om_PIX_X     = pix_x_q;
  assign om_PIX_Y     = pix_y_q;
  assign om_PIX_VALID = pix_valid_q;
  assign om_SOF       = sof_q;
  assign om_EOL       = eol_q;
  assign om_EOF       = eof_q;
  assign om_BUSY      = busy_q;
  assign om_FRAME_CNT = frame_cnt_q;

`ifdef D5M_CAP_LINECHK_EN
  logic line_err_q;

  // Sticky short/long line flag, judged on the count held at the LVAL fall
  always_ff @(posedge im_D5M_PIXLCLK or posedge im_RST) begin
    if (im_RST) line_err_q <= 1'b0;
    else if (start_ok_c) line_err_q <= 1'b0;
    else if ((state_q == ST_CAPTURE) && lv_fall && (x_cnt_q != X_W'(LINE_W))) line_err_q <= 1'b1;
  end

  assign om_LINE_ERR = line_err_q;
`else
  logic unused_line_w;

  assign unused_line_w = |X_W'(LINE_W) | start_ok_c;
  assign om_LINE_ERR   = 1'b0;
`endif

endmodule
